execute_stage_mc: RTL and testbench

EXECUTE_STAGE_MC -- requirements
Module: execute_stage_mc

---
 rtl/execute_stage_mc.sv | 233 +++++++++++++++++++++++
 tb/tb_execute_stage_mc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_mc.sv
// Execute stage: forwarding muxes, single-cycle ALU, branch resolution and a
// radix-2 shift-add multiplier that stalls upstream while it runs.
module execute_stage_mc #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_e,
    input  logic            flush_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pcplus4_e,
    input  logic [XLEN-1:0] imm_ext_e,
    input  logic [REGW-1:0] rd_e,
    input  logic            regwrite_e,
    input  logic            alusrc_e,
    input  logic            memwrite_e,
    input  logic            branch_e,
    input  logic            jump_e,
    input  logic [1:0]      resultsrc_e,
    input  logic [3:0]      alucontrol_e,
    input  logic [1:0]      fwd_a_e,
    input  logic [1:0]      fwd_b_e,
    input  logic [XLEN-1:0] result_w,
    output logic            stall_e,
    output logic            pcsrc_e,
    output logic [XLEN-1:0] pctarget_e,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [XLEN-1:0] pcplus4_m,
    output logic [REGW-1:0] rd_m,
    output logic            valid_m,
    output logic            regwrite_m,
    output logic            memwrite_m,
    output logic [1:0]      resultsrc_m
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memwrite;
        logic [1:0]      resultsrc;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pcplus4;
    } exm_t;

    state_t          state_q, state_d;
    exm_t            exm_q, exm_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res, ex_res;
    logic [SHW-1:0]  shamt;
    logic            zero, mul_req, mul_start, mul_step, load_exm;

    // Operand forwarding; select 11 falls back to the register value
    always_comb begin
        unique case (fwd_a_e)
            2'b01:   src_a = result_w;
            2'b10:   src_a = exm_q.alu_result;
            default: src_a = rd1_e;
        endcase
        unique case (fwd_b_e)
            2'b01:   fwd_b = result_w;
            2'b10:   fwd_b = exm_q.alu_result;
            default: fwd_b = rd2_e;
        endcase
        src_b = alusrc_e ? imm_ext_e : fwd_b;
    end

    assign shamt = src_b[SHW-1:0];

    // Single-cycle ALU; mul and unused encodings read as zero here
    always_comb begin
        alu_res = '0;
        case (alucontrol_e)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLT:  alu_res = ($signed(src_a) < $signed(src_b)) ? XLEN'(1'b1) : '0;
            OP_SLTU: alu_res = (src_a < src_b) ? XLEN'(1'b1) : '0;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(src_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    assign zero       = (alu_res == '0);
    assign pcsrc_e    = valid_e & ~flush_e & ((branch_e & zero) | jump_e);
    assign pctarget_e = pc_e + imm_ext_e;
    assign mul_req    = valid_e & ~flush_e & (alucontrol_e == OP_MUL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_e) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (mul_req) state_d = S_RUN;
                S_RUN:   if (cnt_q == CW'(XLEN - 1)) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Stall and EX/M load decisions; anything not loaded becomes a bubble
    always_comb begin
        stall_e   = 1'b0;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        load_exm  = 1'b0;
        ex_res    = alu_res;
        if (!rst && !flush_e) begin
            case (state_q)
                S_IDLE: begin
                    if (mul_req) begin
                        stall_e   = 1'b1;
                        mul_start = 1'b1;
                    end else begin
                        load_exm = valid_e;
                    end
                end
                S_RUN: begin
                    stall_e  = 1'b1;
                    mul_step = 1'b1;
                end
                S_DONE: begin
                    load_exm = valid_e;
                    ex_res   = acc_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        exm_d = '0;
        if (load_exm) begin
            exm_d.valid      = 1'b1;
            exm_d.regwrite   = regwrite_e;
            exm_d.memwrite   = memwrite_e;
            exm_d.resultsrc  = resultsrc_e;
            exm_d.rd         = rd_e;
            exm_d.alu_result = ex_res;
            exm_d.write_data = fwd_b;
            exm_d.pcplus4    = pcplus4_e;
        end
    end

    // Shift-add multiplier datapath; operands captured only at accept
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (mul_start) begin
            mcand_d  = src_a;
            mplier_d = src_b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (mul_step) begin
            acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            exm_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            exm_q    <= exm_d;
        end
    end

    assign alu_result_m = exm_q.alu_result;
    assign write_data_m = exm_q.write_data;
    assign pcplus4_m    = exm_q.pcplus4;
    assign rd_m         = exm_q.rd;
    assign valid_m      = exm_q.valid;
    assign regwrite_m   = exm_q.regwrite;
    assign memwrite_m   = exm_q.memwrite;
    assign resultsrc_m  = exm_q.resultsrc;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc: vector table for single-cycle ops,
// hand sequences for multiply, flush, branch and reset-abort.
module tb_execute_stage_mc;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_e, flush_e;
    logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pcplus4_e, imm_ext_e, result_w;
    logic [REGW-1:0] rd_e;
    logic            regwrite_e, alusrc_e, memwrite_e, branch_e, jump_e;
    logic [1:0]      resultsrc_e, fwd_a_e, fwd_b_e;
    logic [3:0]      alucontrol_e;
    logic            stall_e, pcsrc_e;
    logic [XLEN-1:0] pctarget_e, alu_result_m, write_data_m, pcplus4_m;
    logic [REGW-1:0] rd_m;
    logic            valid_m, regwrite_m, memwrite_m;
    logic [1:0]      resultsrc_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    execute_stage_mc #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e),
        .imm_ext_e(imm_ext_e), .rd_e(rd_e), .regwrite_e(regwrite_e),
        .alusrc_e(alusrc_e), .memwrite_e(memwrite_e), .branch_e(branch_e),
        .jump_e(jump_e), .resultsrc_e(resultsrc_e), .alucontrol_e(alucontrol_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .result_w(result_w),
        .stall_e(stall_e), .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .pcplus4_m(pcplus4_m), .rd_m(rd_m), .valid_m(valid_m),
        .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .resultsrc_m(resultsrc_m)
    );

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        alusrc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] rw;
        logic [31:0] exp_alu;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_e = 0; flush_e = 0; rd1_e = 0; rd2_e = 0; pc_e = 0; pcplus4_e = 0;
        imm_ext_e = 0; result_w = 0; rd_e = 0; regwrite_e = 0; alusrc_e = 0;
        memwrite_e = 0; branch_e = 0; jump_e = 0; resultsrc_e = 0; alucontrol_e = 0;
        fwd_a_e = 0; fwd_b_e = 0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        idle_inputs();
        valid_e = 1; regwrite_e = 1; rd_e = 5'd7;
        alucontrol_e = op; rd1_e = a; rd2_e = b;
    endtask

    // Called at posedge+1 with a mul already driven; counts stall cycles
    task automatic run_mul(input string nm, input logic [31:0] exp, input bit scramble);
        int scnt = 0;
        int bubbles_bad = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall_e) break;
            scnt++;
            @(posedge clk); #1;
            if (valid_m !== 1'b0 || alu_result_m !== '0) bubbles_bad++;
            if (scramble && scnt == 3) begin
                rd1_e = 32'hDEAD_BEEF; rd2_e = 32'h1234_5678; result_w = 32'hFFFF_FFFF;
            end
        end
        chk({nm, "_stall_cycles"}, 64'(scnt), 64'd33);
        chk({nm, "_bubbles"}, 64'(bubbles_bad), 64'd0);
        @(posedge clk); #1;
        chk({nm, "_result"}, 64'(alu_result_m), 64'(exp));
        chk({nm, "_valid_m"}, 64'(valid_m), 64'd1);
    endtask

    initial begin
        vt[0]  = '{4'd0, 2'b00, 2'b00, 1'b0, 32'd5,         32'd7,         32'd0, 32'd0,         32'd12,        32'd7};
        vt[1]  = '{4'd1, 2'b10, 2'b00, 1'b0, 32'd100,       32'd3,         32'd0, 32'd0,         32'd9,         32'd3};
        vt[2]  = '{4'd0, 2'b01, 2'b00, 1'b1, 32'd100,       32'h55,        32'd1, 32'hFFFF_FFFF, 32'd0,         32'h55};
        vt[3]  = '{4'd2, 2'b00, 2'b00, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0,         32'hF000_F000, 32'hFF00_FF00};
        vt[4]  = '{4'd3, 2'b00, 2'b00, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'd0, 32'd0,         32'hFFFF_F0F0, 32'h0F0F_0000};
        vt[5]  = '{4'd4, 2'b00, 2'b00, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 32'd0,         32'h5555_5555, 32'hFFFF_0000};
        vt[6]  = '{4'd5, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0, 32'd0,         32'd1,         32'd1};
        vt[7]  = '{4'd6, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0, 32'd0,         32'd0,         32'd1};
        vt[8]  = '{4'd7, 2'b00, 2'b00, 1'b0, 32'd1,         32'd31,        32'd0, 32'd0,         32'h8000_0000, 32'd31};
        vt[9]  = '{4'd8, 2'b00, 2'b00, 1'b0, 32'h8000_0000, 32'd4,         32'd0, 32'd0,         32'h0800_0000, 32'd4};
        vt[10] = '{4'd9, 2'b00, 2'b00, 1'b0, 32'h8000_0000, 32'd4,         32'd0, 32'd0,         32'hF800_0000, 32'd4};
        vt[11] = '{4'd7, 2'b00, 2'b00, 1'b0, 32'd3,         32'h21,        32'd0, 32'd0,         32'd6,         32'h21};
        vt[12] = '{4'd11, 2'b00, 2'b00, 1'b0, 32'd5,        32'd6,         32'd0, 32'd0,         32'd0,         32'd6};
        vt[13] = '{4'd1, 2'b00, 2'b01, 1'b0, 32'h20,        32'd99,        32'd0, 32'h10,        32'h10,        32'h10};
        vt[14] = '{4'd0, 2'b11, 2'b11, 1'b0, 32'd9,         32'd1,         32'd0, 32'd0,         32'd10,        32'd1};
        vt[15] = '{4'd1, 2'b00, 2'b00, 1'b0, 32'd0,         32'd1,         32'd0, 32'd0,         32'hFFFF_FFFF, 32'd1};

        // Reset state
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu", 64'(alu_result_m), 64'd0);
        chk("rst_valid", 64'(valid_m), 64'd0);
        chk("rst_stall", 64'(stall_e), 64'd0);
        rst = 0;
        @(posedge clk); #1;

        // Single-cycle vector table
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            valid_e = 1; regwrite_e = 1; rd_e = REGW'(i + 1);
            alucontrol_e = vt[i].op; fwd_a_e = vt[i].fa; fwd_b_e = vt[i].fb;
            alusrc_e = vt[i].alusrc; rd1_e = vt[i].a; rd2_e = vt[i].b;
            imm_ext_e = vt[i].imm; result_w = vt[i].rw;
            pcplus4_e = 32'h1000 + 32'(i * 4); memwrite_e = i[0]; resultsrc_e = i[1:0];
            #1;
            chk($sformatf("v%0d_stall", i), 64'(stall_e), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_alu", i), 64'(alu_result_m), 64'(vt[i].exp_alu));
            chk($sformatf("v%0d_wd", i), 64'(write_data_m), 64'(vt[i].exp_wd));
            chk($sformatf("v%0d_ctl", i), {valid_m, regwrite_m, memwrite_m, resultsrc_m, rd_m},
                {1'b1, 1'b1, i[0], i[1:0], REGW'(i + 1)});
            chk($sformatf("v%0d_pc4", i), 64'(pcplus4_m), 64'(32'h1000 + 32'(i * 4)));
        end

        // valid_e=0 with mul opcode: bubble, no stall
        drive_op(4'd10, 32'd3, 32'd3);
        valid_e = 0;
        #1;
        chk("inv_stall", 64'(stall_e), 64'd0);
        @(posedge clk); #1;
        chk("inv_valid_m", 64'(valid_m), 64'd0);
        chk("inv_rw_m", 64'(regwrite_m), 64'd0);

        // Multiply, operands scrambled mid-run
        drive_op(4'd10, 32'h0001_0001, 32'h0001_0001);
        run_mul("mul", 32'h0002_0001, 1'b1);
        drive_op(4'd0, 32'd1, 32'd1);
        @(posedge clk); #1;
        chk("post_mul_add", 64'(alu_result_m), 64'd2);

        // Flush at RUN cycle 10
        drive_op(4'd10, 32'd6, 32'd7);
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        flush_e = 1;
        #1;
        chk("flush_stall", 64'(stall_e), 64'd0);
        @(posedge clk); #1;
        chk("flush_valid_m", 64'(valid_m), 64'd0);
        drive_op(4'd0, 32'd2, 32'd3);
        #1;
        chk("flush_idle_stall", 64'(stall_e), 64'd0);
        @(posedge clk); #1;
        chk("flush_add", 64'(alu_result_m), 64'd5);
        chk("flush_add_valid", 64'(valid_m), 64'd1);

        // Branch resolution
        drive_op(4'd1, 32'd4, 32'd4);
        branch_e = 1; regwrite_e = 0; pc_e = 32'h100; imm_ext_e = 32'h20;
        #1;
        chk("beq_taken", 64'(pcsrc_e), 64'd1);
        chk("beq_target", 64'(pctarget_e), 64'h120);
        flush_e = 1;
        #1;
        chk("beq_flushed", 64'(pcsrc_e), 64'd0);
        @(posedge clk); #1;
        chk("beq_flush_bubble", 64'(valid_m), 64'd0);
        flush_e = 0; rd2_e = 32'd5;
        #1;
        chk("beq_not_taken", 64'(pcsrc_e), 64'd0);
        jump_e = 1;
        #1;
        chk("jump_taken", 64'(pcsrc_e), 64'd1);
        @(posedge clk); #1;

        // Reset at RUN cycle 5 with the mul still presented
        drive_op(4'd10, 32'd9, 32'd9);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("rstmid_stall", 64'(stall_e), 64'd0);
        chk("rstmid_valid", 64'(valid_m), 64'd0);
        chk("rstmid_alu", 64'(alu_result_m), 64'd0);
        drive_op(4'd0, 32'd40, 32'd2);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        chk("rstmid_add", 64'(alu_result_m), 64'd42);
        drive_op(4'd10, 32'd3, 32'd7);
        run_mul("mul2", 32'd21, 1'b0);
        drive_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mul("mul3", 32'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
